ts_record_packer: RTL
=====================

TS_RECORD_PACKER -- requirements
Module: ts_record_packer

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- ID_W, 3, event ID width (legal 1..8).
- TS_W, 8, timestamp/delta width (legal 1..32); TSB = ceil(TS_W/8) bytes per field.
- RECS_PER_FRM, 4, max records per frame, and buffer depth (legal 1..255).
- FLUSH_TO, 64, idle-cycle timeout before emitting a partial frame (legal >=1).
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock.
- rst, in, 1, reset: synchronous, active-high.
- in_valid, in, 1, result record valid, from the event timestamper output.
- in_ready, out, 1, record accepted when in_valid && in_ready.
- in_id, in, ID_W, event ID.
- in_start_ts, in, TS_W, start timestamp.
- in_end_ts, in, TS_W, end timestamp.
- in_delta, in, TS_W, end - start.
- m_tvalid, out, 1, output byte valid.
- m_tready, in, 1, downstream (UDP payload) ready.
- m_tdata, out, 8, output byte.
- m_tlast, out, 1, last byte of frame.

Function
REQ-003 SHALL buffer accepted records in a FIFO of depth RECS_PER_FRM, in arrival order.
REQ-004 SHALL drive in_ready = (registered occupancy < RECS_PER_FRM), with no combinational path from m_tready.
REQ-005 SHALL allow a push and a pop in the same cycle; occupancy is unchanged in that case.
REQ-006 Frame format SHALL be:
- header byte 0x A5;
- header byte seq (8-bit frame sequence number);
- header byte cnt (records in frame);
- then cnt records, each REC_B = 1+3*TSB bytes: id zero-extended to 8 bits, then start_ts, end_ts, delta, each zero-extended to TSB bytes, MSB byte first.
REQ-007 FSM states SHALL be IDLE, HDR, REC.
- IDLE->HDR when occupancy == RECS_PER_FRM, or when occupancy > 0 and flush timer == FLUSH_TO-1.
- HDR->REC after the 3rd header byte handshake.
- REC->IDLE after the last byte of record cnt.
REQ-008 cnt SHALL be latched from occupancy on IDLE->HDR; records arriving during a frame wait for a later frame.
REQ-009 The flush timer SHALL count cycles in IDLE while occupancy > 0, and clear when occupancy == 0 or on leaving IDLE.
REQ-010 A record SHALL be popped from the FIFO on the handshake of its final byte.
REQ-011 m_tdata/m_tlast SHALL be registered.
- They are held stable while m_tvalid && !m_tready.
- m_tvalid SHALL NOT drop before its handshake.
REQ-012 m_tlast SHALL be 1 only on the final byte of the frame, i.e. byte index 3+cnt*REC_B-1.
REQ-013 seq SHALL increment by 1 (mod 256) after each frame's m_tlast handshake, wrapping 255->0.
REQ-014 A byte SHALL be presented every cycle while m_tready=1, with no bubbles inside a frame.
REQ-015 First header byte SHALL appear on m_tvalid no later than 2 cycles after the IDLE->HDR condition.

Reset
REQ-016 On rst the block SHALL set:
- m_tvalid=0, m_tlast=0, m_tdata=0;
- FSM=IDLE, occupancy=0, flush timer=0, seq=0;
- in_ready=1 from the first cycle after rst deasserts.
REQ-017 rst mid-frame SHALL abort the frame, discarding all buffered records and the partial frame; m_tvalid=0 the next cycle.

Verification
REQ-018 Bench SHALL cover these scenarios (defaults, TS_W=8, REC_B=4):
- Reset: hold rst 4 cycles -> m_tvalid=0, in_ready=1; first frame later carries seq=00.
- Full frame: push ids 0..3 back-to-back, start=0x0A, end=0x14, delta=0x0A, m_tready=1 -> 19 bytes: A5 00 04, then 00 0A 14 0A, 01 0A 14 0A, 02 0A 14 0A, 03 0A 14 0A; tlast only on byte 19.
- Flush: single record id=5, start=0xF0, end=0x05, delta=0x15 -> after 64 idle cycles, 7 bytes A5 01 01 05 F0 05 15; tlast on byte 7.
- Backpressure: random 50% m_tready over the full-frame stimulus -> identical byte sequence, tdata stable while stalled, no lost or duplicated bytes.
- Full buffer: m_tready=0 and 5 records offered -> in_ready=0 after 4 accepted; 5th accepted the cycle after record 0's last byte handshakes; 5th appears in the next frame (cnt=1).
- Reset mid-frame and wrap: rst after byte 5 -> m_tvalid=0 next cycle, next frame seq=00; 256 single-record frames -> seq runs 00..FF then 00.

Source files
------------

// File: rtl/ts_record_packer.sv
// ts_record_packer: buffers event timestamp records in a small FIFO and
// streams them out as byte frames (A5, seq, cnt, then cnt packed records).
// A frame is launched when the buffer fills or after an idle flush timeout.
module ts_record_packer #(
    parameter int ID_W         = 3,
    parameter int TS_W         = 8,
    parameter int RECS_PER_FRM = 4,
    parameter int FLUSH_TO     = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ID_W-1:0] in_id,
    input  logic [TS_W-1:0] in_start_ts,
    input  logic [TS_W-1:0] in_end_ts,
    input  logic [TS_W-1:0] in_delta,
    output logic            m_tvalid,
    input  logic            m_tready,
    output logic [7:0]      m_tdata,
    output logic            m_tlast
);
    localparam int TSB   = (TS_W + 7) / 8;
    localparam int REC_B = 1 + 3 * TSB;
    localparam int VEC_W = REC_B * 8;
    localparam int PTR_W = (RECS_PER_FRM > 1) ? $clog2(RECS_PER_FRM) : 1;
    localparam int OCC_W = $clog2(RECS_PER_FRM + 1);
    localparam int TMR_W = (FLUSH_TO > 1) ? $clog2(FLUSH_TO) : 1;
    localparam logic [7:0] LAST_B = 8'(REC_B - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HDR  = 2'd1;
    localparam logic [1:0] REC  = 2'd2;

    logic [ID_W-1:0]  id_mem [RECS_PER_FRM];
    logic [TS_W-1:0]  st_mem [RECS_PER_FRM];
    logic [TS_W-1:0]  en_mem [RECS_PER_FRM];
    logic [TS_W-1:0]  dl_mem [RECS_PER_FRM];

    logic [1:0]       state;
    logic [OCC_W-1:0] occ;
    logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_inc, rd_ptr_inc;
    logic [TMR_W-1:0] timer;
    logic [7:0]       seq, cnt, byte_idx, rec_idx;
    logic [1:0]       hdr_idx;
    logic             push, pop, hs, start;

    logic [PTR_W-1:0] sel_ptr;
    logic [7:0]       sel_byte, rec_byte, id_ext;
    logic [TSB*8-1:0] st_ext, en_ext, dl_ext;
    logic [VEC_W-1:0] rec_vec, rec_sh;

    assign in_ready   = (occ < OCC_W'(RECS_PER_FRM));
    assign push       = in_valid && in_ready;
    assign hs         = m_tvalid && m_tready;
    assign pop        = (state == REC) && hs && (byte_idx == LAST_B);
    assign start      = (state == IDLE) && (occ != '0) &&
                        ((occ == OCC_W'(RECS_PER_FRM)) || (timer == TMR_W'(FLUSH_TO - 1)));
    assign wr_ptr_inc = (wr_ptr == PTR_W'(RECS_PER_FRM - 1)) ? '0 : wr_ptr + PTR_W'(1);
    assign rd_ptr_inc = (rd_ptr == PTR_W'(RECS_PER_FRM - 1)) ? '0 : rd_ptr + PTR_W'(1);

    // Record storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            id_mem[wr_ptr] <= in_id;
            st_mem[wr_ptr] <= in_start_ts;
            en_mem[wr_ptr] <= in_end_ts;
            dl_mem[wr_ptr] <= in_delta;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave occupancy unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr_inc;
            if (pop)  rd_ptr <= rd_ptr_inc;
            if (push && !pop)      occ <= occ + OCC_W'(1);
            else if (!push && pop) occ <= occ - OCC_W'(1);
        end
    end

    // Flush timer: runs only while idle with records waiting.
    always_ff @(posedge clk) begin
        if (rst || state != IDLE || occ == '0 || start) timer <= '0;
        else                                             timer <= timer + TMR_W'(1);
    end

    // Select the record byte that follows the current one; at a record boundary
    // it comes from the entry after the head, which is the head once the pop lands.
    always_comb begin
        sel_ptr  = rd_ptr;
        sel_byte = '0;
        if (state == REC) begin
            if (byte_idx == LAST_B) sel_ptr = rd_ptr_inc;
            else                    sel_byte = byte_idx + 8'd1;
        end
        id_ext = '0;
        st_ext = '0;
        en_ext = '0;
        dl_ext = '0;
        id_ext[ID_W-1:0] = id_mem[sel_ptr];
        st_ext[TS_W-1:0] = st_mem[sel_ptr];
        en_ext[TS_W-1:0] = en_mem[sel_ptr];
        dl_ext[TS_W-1:0] = dl_mem[sel_ptr];
        rec_vec  = {id_ext, st_ext, en_ext, dl_ext};
        rec_sh   = rec_vec >> (8 * (REC_B - 1 - int'(sel_byte)));
        rec_byte = rec_sh[7:0];
    end

    // Frame sequencer: each handshake loads the next byte into the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            m_tdata  <= '0;
            seq      <= '0;
            cnt      <= '0;
            hdr_idx  <= '0;
            byte_idx <= '0;
            rec_idx  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= HDR;
                        cnt      <= 8'(occ);
                        hdr_idx  <= '0;
                        m_tvalid <= 1'b1;
                        m_tdata  <= 8'hA5;
                        m_tlast  <= 1'b0;
                    end
                end
                HDR: begin
                    if (hs) begin
                        hdr_idx <= hdr_idx + 2'd1;
                        case (hdr_idx)
                            2'd0:    m_tdata <= seq;
                            2'd1:    m_tdata <= cnt;
                            default: begin
                                state    <= REC;
                                byte_idx <= '0;
                                rec_idx  <= '0;
                                m_tdata  <= rec_byte;
                            end
                        endcase
                    end
                end
                REC: begin
                    if (hs) begin
                        if (byte_idx == LAST_B) begin
                            byte_idx <= '0;
                            if (rec_idx == cnt - 8'd1) begin
                                state    <= IDLE;
                                m_tvalid <= 1'b0;
                                m_tlast  <= 1'b0;
                                seq      <= seq + 8'd1;
                            end else begin
                                rec_idx <= rec_idx + 8'd1;
                                m_tdata <= rec_byte;
                            end
                        end else begin
                            byte_idx <= byte_idx + 8'd1;
                            m_tdata  <= rec_byte;
                            m_tlast  <= (rec_idx == cnt - 8'd1) && (byte_idx + 8'd1 == LAST_B);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
